l2_host_tag_sched: RTL and testbench
====================================

Name: l2_host_tag_sched

Overview:
Schedules host read requests from the per-channel L2 request merges onto the single host request port. Round-robin arbitration is gated by a per-channel outstanding-request limit and a global tag pool. Each issued request carries a tag. Returning responses are looked up by tag, the originating stream ID (sid) is recovered, and the tag and channel credit are released. Sits between the per-channel request merge registers and the host interface, and feeds the response demux.

Parameters:
addr_width, 64, host effective-address width in bits
nstrms, 64, total number of streams
nstrms_width, $clog2(nstrms), sid width
channels, 4, number of request channels (power of 2, >=2)
ntags, 32, host tags in pool (power of 2)
tag_width, $clog2(ntags), tag width
max_out, 8, max outstanding requests per channel (1..ntags)
cnt_width, $clog2(max_out+1), per-channel counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
i_req_v  in  channels  per-channel request valid
i_req_r  out  channels  per-channel request ready
i_req_ea  in  channels*addr_width  per-channel request EA
i_req_sid  in  channels*nstrms_width  per-channel global sid
o_req_v  out  1  host request valid
o_req_r  in  1  host request ready
o_req_ea  out  addr_width  host request EA
o_req_tag  out  tag_width  allocated tag
i_rsp_v  in  1  host response valid
i_rsp_r  out  1  host response ready
i_rsp_tag  in  tag_width  response tag
o_rsp_v  out  1  demuxed response valid
o_rsp_r  in  1  demuxed response ready
o_rsp_sid  out  nstrms_width  sid recovered from tag table
o_idle  out  1  no tags allocated and both output registers empty
o_err  out  1  sticky error (only with L2_TAG_SCHED_ERR_CHK_EN)

Behaviour:
- Reset values (reset low, asynchronous): o_req_v=0, o_rsp_v=0, o_req_ea/o_req_tag/o_rsp_sid=0, all tags free, all channel counters 0, RR pointer 0, o_idle=1, o_err=0.
- Eligibility: channel c is eligible when i_req_v[c]=1, cnt[c]<max_out and at least one tag is free.
- Request output register (1 entry) may load when o_req_v=0 or o_req_r=1.
- Arbitration: when the register may load, grant the first eligible channel at or after the RR pointer (wrapping). Set i_req_r[winner]=1; all other i_req_r=0.
- i_req_r is combinational from the current state and i_req_v. Ready is never asserted to a non-winning channel.
- On grant:
  - load EA into the output register;
  - allocate the lowest-index free tag and write {sid, channel} into the tag table;
  - cnt[winner]+=1;
  - RR pointer := winner+1 mod channels.
- Without a grant, the RR pointer holds.
- Request latency: 1 cycle from accepted i_req to o_req_v. With o_req_r held high, sustained throughput is 1 request/cycle.
- The output register holds EA and tag stable while o_req_v=1 and o_req_r=0.
- Response path:
  - i_rsp_r = (o_rsp_v==0) or o_rsp_r.
  - On i_rsp handshake: o_rsp_sid := table[i_rsp_tag].sid next cycle and o_rsp_v=1 (latency 1). In the same cycle the tag is freed and cnt[table[tag].chan] -= 1.
- Simultaneous events:
  - Allocation uses the free mask from before the same-cycle release, so a tag freed this cycle is reusable next cycle.
  - Increment and decrement of the same counter in one cycle leave it unchanged.
- Boundaries:
  - All tags allocated: no grants; i_req_r=0 on all channels.
  - cnt[c]==max_out: channel c is skipped and the remaining channels still arbitrate.
  - A response for a tag not currently allocated: accepted, no tag or counter change, o_rsp_v not raised.
- o_idle = (free mask all ones) & !o_req_v & !o_rsp_v.

Optional Feature:
L2_TAG_SCHED_ERR_CHK_EN
- Defined: o_err is present. It is set and held until reset by:
  - a response to an unallocated tag;
  - a counter underflow attempt;
  - o_req_ea or o_req_tag changing while o_req_v=1 and o_req_r=0.
- Undefined: o_err port absent, no checking logic; unallocated-tag responses are still ignored.

Test Plan:
- Reset released, no stimulus -> o_req_v=0, o_rsp_v=0, o_idle=1, i_req_r=0000.
- i_req_v=1111, o_req_r=1, no responses, max_out=8 -> grants in order ch0,1,2,3,0,...; tags 0..31 issued in order; after 32 grants i_req_r=0000 and o_req_v drops.
- Only ch2 requests, max_out=2 -> two grants (tags 0,1), then i_req_r[2]=0. Response tag 0 -> o_rsp_sid equals ch2's first sid one cycle later, and the next grant reuses tag 0.
- o_req_r=0 for 5 cycles with o_req_v=1 -> o_req_ea and o_req_tag constant, no new grant; o_req_r=1 -> next request follows in the next cycle.
- Tag pool full, i_rsp tag 7 accepted while all channels request -> tag 7 is granted the following cycle to the RR-next channel; cnt of tag 7's channel is unchanged if that channel wins.
- Response with tag 5 never allocated (ERR_CHK_EN defined) -> i_rsp_r=1, o_rsp_v stays 0, o_err=1 and sticky until reset.

Source files
------------

// File: rtl/l2_host_tag_sched.sv
// l2_host_tag_sched
// Schedules host read requests from per-channel request merges onto the
// single host request port. Round-robin arbitration is gated by a
// per-channel outstanding limit and a global tag pool. Responses are looked
// up by tag to recover the sid, and the tag and channel credit are released.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   i_req_v/r/ea/sid     per-channel request inputs (packed by channel)
//   o_req_v/r/ea/tag     host request output register (1 entry)
//   i_rsp_v/r/tag        host response input
//   o_rsp_v/r/sid        demuxed response output register (1 entry)
//   o_idle               no tags allocated and both output registers empty
//   o_err                sticky error, present only with L2_TAG_SCHED_ERR_CHK_EN
//
// Optional: define L2_TAG_SCHED_ERR_CHK_EN to add o_err and its checkers.
module l2_host_tag_sched #(
    parameter int addr_width   = 64,
    parameter int nstrms       = 64,
    parameter int nstrms_width = $clog2(nstrms),
    parameter int channels     = 4,
    parameter int ntags        = 32,
    parameter int tag_width    = $clog2(ntags),
    parameter int max_out      = 8,
    parameter int cnt_width    = $clog2(max_out + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [channels-1:0]              i_req_v,
    output logic [channels-1:0]              i_req_r,
    input  logic [channels*addr_width-1:0]   i_req_ea,
    input  logic [channels*nstrms_width-1:0] i_req_sid,
    output logic                             o_req_v,
    input  logic                             o_req_r,
    output logic [addr_width-1:0]            o_req_ea,
    output logic [tag_width-1:0]             o_req_tag,
    input  logic                             i_rsp_v,
    output logic                             i_rsp_r,
    input  logic [tag_width-1:0]             i_rsp_tag,
    output logic                             o_rsp_v,
    input  logic                             o_rsp_r,
    output logic [nstrms_width-1:0]          o_rsp_sid,
    output logic                             o_idle
`ifdef L2_TAG_SCHED_ERR_CHK_EN
    ,
    output logic                             o_err
`endif
);

    localparam int chan_width = $clog2(channels);

    logic [ntags-1:0]                  free;
    logic [nstrms_width-1:0]           tbl_sid  [ntags];
    logic [chan_width-1:0]             tbl_chan [ntags];
    logic [channels-1:0][cnt_width-1:0] cnt;
    logic [chan_width-1:0]             rr;

    logic                  ld;
    logic                  grant;
    logic [chan_width-1:0] winner;
    logic [chan_width-1:0] idx;
    logic [tag_width-1:0]  alloc_tag;
    logic                  alloc_found;
    logic                  rsp_hs;
    logic                  rsp_hit;
    logic [chan_width-1:0] rsp_chan;
    logic                  dec_ok;

    assign ld       = !o_req_v || o_req_r;
    assign i_rsp_r  = !o_rsp_v || o_rsp_r;
    assign rsp_hs   = i_rsp_v && i_rsp_r;
    assign rsp_hit  = rsp_hs && !free[i_rsp_tag];
    assign rsp_chan = tbl_chan[i_rsp_tag];
    // A decrement of an empty counter can only come from a corrupted table;
    // it is dropped rather than wrapping.
    assign dec_ok   = rsp_hit && (cnt[rsp_chan] != '0);
    assign o_idle   = (&free) && !o_req_v && !o_rsp_v;

    // Round-robin scan starting at rr; the chan_width-wide add wraps.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        idx    = '0;
        if (ld && (|free)) begin
            for (int k = 0; k < channels; k++) begin
                idx = rr + chan_width'(k);
                if (!grant && i_req_v[idx] && (cnt[idx] < cnt_width'(max_out))) begin
                    grant  = 1'b1;
                    winner = idx;
                end
            end
        end
    end

    always_comb begin
        i_req_r = '0;
        if (grant) i_req_r[winner] = 1'b1;
    end

    // Lowest free tag, taken from the mask before this cycle's release.
    always_comb begin
        alloc_tag   = '0;
        alloc_found = 1'b0;
        for (int t = 0; t < ntags; t++) begin
            if (!alloc_found && free[t]) begin
                alloc_tag   = tag_width'(t);
                alloc_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_req_v   <= 1'b0;
            o_req_ea  <= '0;
            o_req_tag <= '0;
            rr        <= '0;
        end else if (ld) begin
            o_req_v <= grant;
            if (grant) begin
                o_req_ea  <= i_req_ea[winner*addr_width +: addr_width];
                o_req_tag <= alloc_tag;
                rr        <= winner + chan_width'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_rsp_v   <= 1'b0;
            o_rsp_sid <= '0;
        end else if (rsp_hit) begin
            o_rsp_v   <= 1'b1;
            o_rsp_sid <= tbl_sid[i_rsp_tag];
        end else if (o_rsp_r) begin
            o_rsp_v <= 1'b0;
        end
    end

    // Allocated and released tags in one cycle are always distinct.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free <= '1;
            for (int t = 0; t < ntags; t++) begin
                tbl_sid[t]  <= '0;
                tbl_chan[t] <= '0;
            end
        end else begin
            if (grant) begin
                free[alloc_tag]     <= 1'b0;
                tbl_sid[alloc_tag]  <= i_req_sid[winner*nstrms_width +: nstrms_width];
                tbl_chan[alloc_tag] <= winner;
            end
            if (rsp_hit) free[i_rsp_tag] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            for (int c = 0; c < channels; c++) begin
                if ((grant && winner == chan_width'(c)) && !(dec_ok && rsp_chan == chan_width'(c)))
                    cnt[c] <= cnt[c] + cnt_width'(1);
                else if (!(grant && winner == chan_width'(c)) && (dec_ok && rsp_chan == chan_width'(c)))
                    cnt[c] <= cnt[c] - cnt_width'(1);
            end
        end
    end

`ifdef L2_TAG_SCHED_ERR_CHK_EN
    logic                  err;
    logic                  stall_q;
    logic [addr_width-1:0] ea_q;
    logic [tag_width-1:0]  tag_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err     <= 1'b0;
            stall_q <= 1'b0;
            ea_q    <= '0;
            tag_q   <= '0;
        end else begin
            stall_q <= o_req_v && !o_req_r;
            ea_q    <= o_req_ea;
            tag_q   <= o_req_tag;
            if ((rsp_hs && free[i_rsp_tag]) ||
                (rsp_hit && cnt[rsp_chan] == '0) ||
                (stall_q && (ea_q != o_req_ea || tag_q != o_req_tag)))
                err <= 1'b1;
        end
    end

    assign o_err = err;
`endif

endmodule

// File: tb/tb_l2_host_tag_sched.sv
module tb_l2_host_tag_sched;
    localparam int AW = 64, SW = 6, C = 4, NT = 32, TW = 5, MO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [C-1:0]    i_req_v, i_req_r;
    logic [C*AW-1:0] i_req_ea;
    logic [C*SW-1:0] i_req_sid;
    logic            o_req_v, o_req_r;
    logic [AW-1:0]   o_req_ea;
    logic [TW-1:0]   o_req_tag;
    logic            i_rsp_v, i_rsp_r;
    logic [TW-1:0]   i_rsp_tag;
    logic            o_rsp_v, o_rsp_r;
    logic [SW-1:0]   o_rsp_sid;
    logic            o_idle;
`ifdef L2_TAG_SCHED_ERR_CHK_EN
    logic            o_err;
`endif

    l2_host_tag_sched dut (
        .clk(clk), .reset(reset),
        .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_ea(i_req_ea), .i_req_sid(i_req_sid),
        .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_ea(o_req_ea), .o_req_tag(o_req_tag),
        .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_tag(i_rsp_tag),
        .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r), .o_rsp_sid(o_rsp_sid),
        .o_idle(o_idle)
`ifdef L2_TAG_SCHED_ERR_CHK_EN
        , .o_err(o_err)
`endif
    );

    int checks = 0, errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: set of outstanding tags with their owner, plus the
    // two output registers and the round-robin start channel.
    bit          m_alloc [NT];
    int          m_sid   [NT];
    int          m_chan  [NT];
    int          m_rr;
    bit          m_req_v;
    logic [63:0] m_req_ea;
    int          m_req_tag;
    bit          m_rsp_v;
    int          m_rsp_sid;
    bit          m_err;
    logic [C-1:0] smp_req_r;

    function automatic int n_alloc();
        int n = 0;
        for (int t = 0; t < NT; t++) n += int'(m_alloc[t]);
        return n;
    endfunction

    function automatic int n_alloc_of(int c);
        int n = 0;
        for (int t = 0; t < NT; t++) if (m_alloc[t] && m_chan[t] == c) n++;
        return n;
    endfunction

    // One clock: check combinational outputs, advance the model, then check
    // the registered outputs after the edge.
    task automatic cycle();
        int w, ft;
        bit ld, rr_exp, hs, hit;
        logic [C-1:0] er;
        #1;
        ld = !m_req_v || o_req_r;
        w  = -1;
        if (ld && n_alloc() < NT)
            for (int k = 0; k < C; k++) begin
                int c;
                c = (m_rr + k) % C;
                if (w < 0 && i_req_v[c] && n_alloc_of(c) < MO) w = c;
            end
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        smp_req_r = i_req_r;
        chk("i_req_r", 64'(i_req_r), 64'(er));
        rr_exp = !m_rsp_v || o_rsp_r;
        chk("i_rsp_r", 64'(i_rsp_r), 64'(rr_exp));
        hs  = i_rsp_v && rr_exp;
        hit = hs && m_alloc[i_rsp_tag];
        ft  = -1;
        for (int t = 0; t < NT; t++) if (ft < 0 && !m_alloc[t]) ft = t;
        if (hs && !hit) m_err = 1'b1;
        if (hit) begin
            m_rsp_v   = 1'b1;
            m_rsp_sid = m_sid[i_rsp_tag];
            m_alloc[i_rsp_tag] = 1'b0;
        end else if (o_rsp_r) m_rsp_v = 1'b0;
        if (ld) begin
            m_req_v = (w >= 0);
            if (w >= 0) begin
                m_req_ea   = i_req_ea[w*AW +: AW];
                m_req_tag  = ft;
                m_alloc[ft] = 1'b1;
                m_sid[ft]  = int'(i_req_sid[w*SW +: SW]);
                m_chan[ft] = w;
                m_rr       = (w + 1) % C;
            end
        end
        @(posedge clk);
        #1;
        chk("o_req_v", 64'(o_req_v), 64'(m_req_v));
        if (m_req_v) begin
            chk("o_req_ea", o_req_ea, m_req_ea);
            chk("o_req_tag", 64'(o_req_tag), 64'(m_req_tag));
        end
        chk("o_rsp_v", 64'(o_rsp_v), 64'(m_rsp_v));
        if (m_rsp_v) chk("o_rsp_sid", 64'(o_rsp_sid), 64'(m_rsp_sid));
        chk("o_idle", 64'(o_idle), 64'(n_alloc() == 0 && !m_req_v && !m_rsp_v));
`ifdef L2_TAG_SCHED_ERR_CHK_EN
        chk("o_err", 64'(o_err), 64'(m_err));
`endif
    endtask

    task automatic set_req(logic [C-1:0] v);
        i_req_v = v;
        for (int c = 0; c < C; c++) begin
            i_req_ea[c*AW +: AW]  = {$urandom(), $urandom()};
            i_req_sid[c*SW +: SW] = SW'($urandom());
        end
    endtask

    // Mostly responses to outstanding tags, occasionally an arbitrary tag.
    task automatic pick_rsp();
        int q[$];
        i_rsp_v   = 1'b0;
        i_rsp_tag = '0;
        for (int t = 0; t < NT; t++) if (m_alloc[t]) q.push_back(t);
        if (q.size() > 0 && $urandom_range(99) < 40) begin
            i_rsp_v   = 1'b1;
            i_rsp_tag = TW'(q[$urandom_range(q.size() - 1)]);
        end else if ($urandom_range(99) < 3) begin
            i_rsp_v   = 1'b1;
            i_rsp_tag = TW'($urandom());
        end
    endtask

    task automatic drain();
        o_req_r = 1'b1;
        for (int i = 0; i < 600 && !(n_alloc() == 0 && !m_req_v && !m_rsp_v); i++) begin
            set_req('0);
            pick_rsp();
            o_rsp_r = 1'($urandom());
            cycle();
        end
        chk("drain_idle", 64'(o_idle), 64'd1);
    endtask

    logic [63:0] gea  [NT];
    int          gsid [NT];
    int          g, sid_first;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int t = 0; t < NT; t++) begin
            m_alloc[t] = 0; m_sid[t] = 0; m_chan[t] = 0;
        end
        m_rr = 0; m_req_v = 0; m_req_ea = '0; m_req_tag = 0;
        m_rsp_v = 0; m_rsp_sid = 0; m_err = 0;
        reset = 1'b0;
        i_req_v = '0; i_req_ea = '0; i_req_sid = '0;
        o_req_r = 1'b0; i_rsp_v = 1'b0; i_rsp_tag = '0; o_rsp_r = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_o_req_v", 64'(o_req_v), 64'd0);
        chk("rst_o_rsp_v", 64'(o_rsp_v), 64'd0);
        chk("rst_o_idle", 64'(o_idle), 64'd1);
        chk("rst_i_req_r", 64'(i_req_r), 64'd0);
        chk("rst_o_req_ea", o_req_ea, 64'd0);
        chk("rst_o_req_tag", 64'(o_req_tag), 64'd0);
        chk("rst_o_rsp_sid", 64'(o_rsp_sid), 64'd0);
`ifdef L2_TAG_SCHED_ERR_CHK_EN
        chk("rst_o_err", 64'(o_err), 64'd0);
`endif

        // All channels request with the host always ready; stall after 16.
        o_req_r = 1'b1; o_rsp_r = 1'b1;
        g = 0;
        for (int cyc = 0; cyc < 200 && g < 32; cyc++) begin
            set_req(4'hF);
            if (g == 16 && o_req_r) begin
                o_req_r = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    set_req(4'hF);
                    cycle();
                    chk("stall_no_grant", 64'(smp_req_r), 64'd0);
                    chk("stall_ea", o_req_ea, gea[15]);
                    chk("stall_tag", 64'(o_req_tag), 64'd15);
                end
                o_req_r = 1'b1;
                set_req(4'hF);
            end
            gea[g]  = i_req_ea[(g % 4)*AW +: AW];
            gsid[g] = int'(i_req_sid[(g % 4)*SW +: SW]);
            cycle();
            if (smp_req_r != '0) begin
                chk("rr_order", 64'(smp_req_r), 64'(1) << (g % 4));
                chk("tag_order", 64'(o_req_tag), 64'(g));
                g++;
            end
        end
        chk("grant_count", 64'(g), 64'd32);
        set_req(4'hF);
        cycle();
        chk("full_no_grant", 64'(smp_req_r), 64'd0);
        chk("full_req_v_drop", 64'(o_req_v), 64'd0);

        // Pool full: release tag 7 (owned by ch3) while everyone requests.
        set_req(4'hF);
        i_rsp_v = 1'b1; i_rsp_tag = TW'(7);
        cycle();
        chk("rel_same_cycle_no_grant", 64'(smp_req_r), 64'd0);
        chk("rel_rsp_v", 64'(o_rsp_v), 64'd1);
        chk("rel_rsp_sid", 64'(o_rsp_sid), 64'(gsid[7]));
        i_rsp_v = 1'b0;
        set_req(4'hF);
        cycle();
        chk("reuse_winner", 64'(smp_req_r), 64'h8);
        chk("reuse_tag", 64'(o_req_tag), 64'd7);
        set_req(4'hF);
        cycle();
        chk("reuse_cnt_kept", 64'(smp_req_r), 64'd0);
        drain();

        // Only ch2 requests: limited by its outstanding count, not the pool.
        for (int i = 0; i < MO; i++) begin
            set_req(4'b0100);
            if (i == 0) sid_first = int'(i_req_sid[2*SW +: SW]);
            cycle();
            chk("ch2_grant", 64'(smp_req_r), 64'h4);
            chk("ch2_tag", 64'(o_req_tag), 64'(i));
        end
        set_req(4'b0100);
        cycle();
        chk("ch2_at_limit", 64'(smp_req_r), 64'd0);
        set_req(4'b0101);
        cycle();
        chk("skip_limited", 64'(smp_req_r), 64'h1);
        chk("skip_tag", 64'(o_req_tag), 64'd8);
        set_req(4'b0100);
        i_rsp_v = 1'b1; i_rsp_tag = '0;
        cycle();
        i_rsp_v = 1'b0;
        chk("ch2_rsp_v", 64'(o_rsp_v), 64'd1);
        chk("ch2_rsp_sid", 64'(o_rsp_sid), 64'(sid_first));
        set_req(4'b0100);
        cycle();
        chk("ch2_regrant", 64'(smp_req_r), 64'h4);
        chk("ch2_tag0_reuse", 64'(o_req_tag), 64'd0);
        drain();

        // Randomized traffic with backpressure on both sides.
        for (int i = 0; i < 3000; i++) begin
            set_req(C'($urandom()));
            o_req_r = ($urandom_range(99) < 70);
            o_rsp_r = ($urandom_range(99) < 70);
            pick_rsp();
            cycle();
        end
        drain();

        // Response to a never-allocated tag while idle is accepted and dropped.
        set_req('0);
        o_rsp_r = 1'b1;
        i_rsp_v = 1'b1; i_rsp_tag = TW'(5);
        cycle();
        i_rsp_v = 1'b0;
        chk("stray_rsp_v", 64'(o_rsp_v), 64'd0);
        chk("stray_idle", 64'(o_idle), 64'd1);
`ifdef L2_TAG_SCHED_ERR_CHK_EN
        chk("stray_err", 64'(o_err), 64'd1);
        cycle();
        chk("stray_err_sticky", 64'(o_err), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
